// File: rtl/two_port_mem_reader_if.sv
// Bundle of the command, memory read port and output stream signals of
// two_port_mem_reader. The reader sits on the slave side; whoever issues
// commands, models the memory and consumes the stream uses the master side.
interface two_port_mem_reader_if #(
    parameter int addresses = 32,
    parameter int width     = 8
);
    localparam int addressWidth = (addresses > 1) ? $clog2(addresses) : 1;

    logic                    start;
    logic [addressWidth-1:0] startAddress;
    logic [addressWidth:0]   count;
    logic                    busy;
    logic                    done;
    logic [addressWidth-1:0] readAddress;
    logic                    readEnable;
    logic [width-1:0]        readData;
    logic [width-1:0]        outData;
    logic                    outValid;
    logic                    outReady;

    modport slave (
        input  start, startAddress, count, readData, outReady,
        output busy, done, readAddress, readEnable, outData, outValid
    );

    modport master (
        output start, startAddress, count, readData, outReady,
        input  busy, done, readAddress, readEnable, outData, outValid
    );
endinterface

// File: rtl/two_port_mem_reader.sv
// Streaming block-read engine for the read port of a two-port memory.
// A start pulse reads `count` consecutive words (wrapping modulo `addresses`)
// and streams them out on valid/ready. A 3-entry skid buffer absorbs the
// one-cycle memory latency so the stream runs at one word per cycle when the
// consumer is always ready. Issue is decided from registered state only, so
// there is no combinational path from outReady to readEnable.
module two_port_mem_reader #(
    parameter int addresses = 32,
    parameter int width     = 8
) (
    input  logic                     clk,
    input  logic                     resetN,
    two_port_mem_reader_if.slave     bus
);
    localparam int addressWidth = (addresses > 1) ? $clog2(addresses) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                  state;
    logic                    busy_q;
    logic                    done_q;
    logic [addressWidth-1:0] next_addr;
    logic [addressWidth:0]   issue_left;
    logic [addressWidth:0]   deliver_left;
    logic                    inflight;
    logic [1:0]              occupancy;
    logic [1:0]              head;
    logic [1:0]              tail;
    logic [width-1:0]        fifo_mem [3];

    logic                    read_en;
    logic                    out_valid;
    logic                    push;
    logic                    pop;
    logic                    accept_start;

    // Wrap the read address at the top of the memory, which need not be a power of two.
    function automatic logic [addressWidth-1:0] addr_inc(input logic [addressWidth-1:0] a);
        if (a == addressWidth'(addresses - 1)) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    // Buffer pointers cycle through 0,1,2.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already buffered plus the one possibly in flight must leave room
    // for the word this issue will bring back.
    assign read_en      = (state == RUN) && (issue_left != '0) &&
                          (({1'b0, occupancy} + {2'b00, inflight}) <= 3'd2);
    assign out_valid    = (occupancy != 2'd0);
    assign push         = inflight;
    assign pop          = out_valid && bus.outReady;
    assign accept_start = (state == IDLE) && bus.start;

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.readAddress = next_addr;
    assign bus.readEnable  = read_en;
    assign bus.outValid    = out_valid;
    assign bus.outData     = out_valid ? fifo_mem[head] : '0;

    // Transfer sequencing: IDLE -> RUN -> FINISH (one cycle) -> IDLE, with registered busy/done.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.count == '0) begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pop && deliver_left == (addressWidth+1)'(1)) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Address and word counters; operands are latched only when a start is accepted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            next_addr    <= '0;
            issue_left   <= '0;
            deliver_left <= '0;
            inflight     <= 1'b0;
        end else begin
            inflight <= read_en;
            if (accept_start) begin
                next_addr    <= bus.startAddress;
                issue_left   <= bus.count;
                deliver_left <= bus.count;
            end else begin
                if (read_en) begin
                    next_addr  <= addr_inc(next_addr);
                    issue_left <= issue_left - 1'b1;
                end
                if (pop) begin
                    deliver_left <= deliver_left - 1'b1;
                end
            end
        end
    end

    // Skid buffer bookkeeping: push returning read data, pop on handshake.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            occupancy <= 2'd0;
            head      <= 2'd0;
            tail      <= 2'd0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (push && !pop) begin
                occupancy <= occupancy + 2'd1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 2'd1;
            end
        end
    end

    // Buffer storage holds data only; its contents are meaningless while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail] <= bus.readData;
        end
    end
endmodule

// File: tb/tb_two_port_mem_reader.sv
// Bench for two_port_mem_reader: memory model, scoreboard queue filled at
// start time from the memory contents, and an independent stream monitor.
module tb_two_port_mem_reader;
    localparam int ADDRS = 32;
    localparam int W     = 8;
    localparam int AW    = $clog2(ADDRS);

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    always #5 clk = ~clk;

    two_port_mem_reader_if #(.addresses(ADDRS), .width(W)) bus ();

    two_port_mem_reader #(.addresses(ADDRS), .width(W)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    logic [W-1:0] mem [ADDRS];
    logic [W-1:0] exp_q [$];

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int re_seen = 0;
    int words_seen = 0;
    int outstanding = 0;
    bit stall_prev = 1'b0;
    logic [W-1:0] stall_data = '0;

    // Memory read port with one cycle of latency.
    always @(posedge clk) begin
        if (bus.readEnable) bus.readData <= mem[bus.readAddress];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stream monitor: samples mid-cycle, before the edge that completes a handshake.
    always @(negedge clk) begin
        if (!resetN) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(bus.outValid), 32'd1);
                check("hold_data", 32'(bus.outData), 32'(stall_data));
            end
            check("outstanding_bound", 32'(outstanding <= 3), 32'd1);
            if (outstanding == 3) check("issue_stall_when_full", 32'(bus.readEnable), 32'd0);
            if (bus.outValid && bus.outReady) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(bus.outData), 32'hFFFF_FFFF);
                end else begin
                    check("word", 32'(bus.outData), 32'(exp_q.pop_front()));
                end
            end
            if (bus.done) done_seen++;
            if (bus.readEnable) re_seen++;
            outstanding = outstanding + (bus.readEnable ? 1 : 0) - ((bus.outValid && bus.outReady) ? 1 : 0);
            stall_prev = bus.outValid && !bus.outReady;
            stall_data = bus.outData;
        end
    end

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            1:       return (k % 3) == 0;
            2:       return $urandom_range(0, 3) != 0;
            3:       return !(k >= 2 && k <= 6);
            default: return 1'b1;
        endcase
    endfunction

    // Issue one transfer (called just after a rising edge) and run it to done.
    task automatic run_xfer(input int sa, input int cnt, input int mode, input bit poke,
                            output int first_v, output int vcnt, output int last_v,
                            output int done_k, output int re_cnt);
        int d0;
        int r0;
        bit got;
        d0 = done_seen; r0 = re_seen;
        first_v = -1; last_v = -1; vcnt = 0; done_k = -1; got = 1'b0;
        bus.start        = 1'b1;
        bus.startAddress = AW'(sa);
        bus.count        = (AW+1)'(cnt);
        bus.outReady     = ready_for(mode, 0);
        for (int i = 0; i < cnt; i++) exp_q.push_back(mem[(sa + i) % ADDRS]);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.outValid) begin
                vcnt++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
            if (bus.done) begin
                got = 1'b1;
                done_k = k;
                break;
            end
            @(posedge clk); #1;
            bus.outReady = ready_for(mode, k + 1);
            if (poke && k == 4) begin
                bus.start        = 1'b1;
                bus.startAddress = AW'(sa + 7);
                bus.count        = (AW+1)'(3);
            end else begin
                bus.start = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        re_cnt = re_seen - r0;
        check("done_reached", 32'(got), 32'd1);
        check("done_once", 32'(done_seen - d0), 32'd1);
        check("busy_clear", 32'(bus.busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int fv, vc, lv, dk, rc, base;
        bus.start = 1'b0; bus.startAddress = '0; bus.count = '0; bus.outReady = 1'b0;
        bus.readData = '0;
        for (int i = 0; i < ADDRS; i++) mem[i] = W'(i);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_readEnable", 32'(bus.readEnable), 32'd0);
        check("rst_readAddress", 32'(bus.readAddress), 32'd0);
        check("rst_outValid", 32'(bus.outValid), 32'd0);
        check("rst_outData", 32'(bus.outData), 32'd0);
        #2 resetN = 1'b1;
        @(posedge clk); #1;

        // Full sweep
        run_xfer(0, 32, 0, 1'b0, fv, vc, lv, dk, rc);
        check("sweep_first_valid_latency", 32'(fv), 32'd2);
        check("sweep_valid_cycles", 32'(vc), 32'd32);
        check("sweep_no_bubbles", 32'(lv - fv + 1), 32'd32);
        check("sweep_reads", 32'(rc), 32'd32);

        // Wrap-around
        run_xfer(30, 4, 0, 1'b0, fv, vc, lv, dk, rc);
        check("wrap_valid_cycles", 32'(vc), 32'd4);

        // Backpressure: toggling ready, then a long stall
        for (int i = 0; i < ADDRS; i++) mem[i] = W'($urandom);
        run_xfer(3, 8, 1, 1'b0, fv, vc, lv, dk, rc);
        check("bp_toggle_reads", 32'(rc), 32'd8);
        run_xfer(27, 8, 3, 1'b0, fv, vc, lv, dk, rc);
        check("bp_stall_reads", 32'(rc), 32'd8);

        // Zero count
        run_xfer(9, 0, 0, 1'b0, fv, vc, lv, dk, rc);
        check("zero_done_cycle", 32'(dk), 32'd0);
        check("zero_no_reads", 32'(rc), 32'd0);
        check("zero_no_valid", 32'(vc), 32'd0);

        // Start while busy
        run_xfer(12, 10, 0, 1'b1, fv, vc, lv, dk, rc);
        check("busy_start_reads", 32'(rc), 32'd10);

        // Randomized transfers
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < ADDRS; i++) mem[i] = W'($urandom);
            run_xfer(int'($urandom_range(0, ADDRS - 1)), int'($urandom_range(0, ADDRS)),
                     int'($urandom_range(0, 3)), 1'(t[0]), fv, vc, lv, dk, rc);
        end

        // Reset mid-transfer after three words
        base = words_seen;
        bus.start = 1'b1; bus.startAddress = AW'(20); bus.count = (AW+1)'(16); bus.outReady = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(mem[(20 + i) % ADDRS]);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 50 && words_seen < base + 3; k++) begin
            @(posedge clk); #2;
        end
        check("rst_mid_words", 32'(words_seen - base), 32'd3);
        resetN = 1'b0;
        #1;
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        check("rst_mid_readEnable", 32'(bus.readEnable), 32'd0);
        check("rst_mid_readAddress", 32'(bus.readAddress), 32'd0);
        check("rst_mid_outValid", 32'(bus.outValid), 32'd0);
        check("rst_mid_outData", 32'(bus.outData), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 resetN = 1'b1;
        @(posedge clk); #1;
        run_xfer(5, 2, 0, 1'b0, fv, vc, lv, dk, rc);
        check("post_rst_valid_cycles", 32'(vc), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
